// File: rtl/fft_pkg.sv
// Shared FFT definitions: bit-reversal helper, reorder FSM state encodings,
// and the complex sample packing convention.
package fft_pkg;

    // A complex sample is stored as one word: {real, imag}, real in the upper half.
    localparam int SAMPLE_REAL_IS_MSB = 1;

    typedef enum logic {
        W_WAIT = 1'b0,
        W_FILL = 1'b1
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rstate_t;

    // Reverses the low 'width' bits of val; bits above 'width' come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] src;
        logic [31:0] res;
        src = val;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res = {res[30:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_delay.sv
// Fixed-length pipeline delay with async reset; DELAY clocks, no backpressure.
module fft_delay #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DELAY-1];

endmodule

// File: rtl/ram2p.sv
// Simple dual-port RAM: one write port, one read port with RD_LATENCY clocks
// of registered read delay; no backpressure.
module ram2p #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Data contents are not reset; consumers qualify them with their own valid.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_pipe[0] <= mem[rd_addr];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rd_dat = rd_pipe[RD_LATENCY-1];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed frames in, natural-order frames out.
// First output RAM_RD_LATENCY+1 clocks after the last input; no backpressure, overruns set err_o.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int STATE_N        = 4096,
    parameter int ADDR_WIDTH     = 12,
    parameter int RAM_RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sig_start_i,
    input  logic                  sig_vld_i,
    input  logic [DATA_WIDTH-1:0] sig_real_i,
    input  logic [DATA_WIDTH-1:0] sig_imag_i,
    output logic                  sig_start_o,
    output logic                  sig_vld_o,
    output logic [DATA_WIDTH-1:0] sig_real_o,
    output logic [DATA_WIDTH-1:0] sig_imag_o,
    output logic                  err_o
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(STATE_N - 1);

    wstate_t                 wstate, wstate_nxt;
    logic [ADDR_WIDTH-1:0]   wcnt, wcnt_nxt;
    logic                    wbank, wbank_nxt;
    rstate_t                 rstate, rstate_nxt;
    logic [ADDR_WIDTH-1:0]   rcnt, rcnt_nxt;
    logic                    rbank, rbank_nxt;
    logic [1:0]              full, full_set, full_clr;
    logic                    err, err_set;
    logic                    wfull;
    logic                    issue, rd_last;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [SW-1:0]           wr_dat, rd_dat0, rd_dat1, rd_sample;
    logic [2:0]              dly_in, dly_out;
    logic                    rd_sel;

    assign wr_dat   = {sig_real_i, sig_imag_i};
    assign issue    = (rstate == R_READ);
    assign rd_last  = issue && (rcnt == LAST_ADDR);
    assign full_clr = rd_last ? (2'b01 << rbank) : 2'b00;
    // A bank whose last read issues this cycle is free for a write starting now,
    // which is what lets back-to-back frames flow without a drop.
    assign wfull    = full[wbank] && !full_clr[wbank];

    always_comb begin
        wstate_nxt = wstate;
        wcnt_nxt   = wcnt;
        wbank_nxt  = wbank;
        wr_en      = 1'b0;
        wr_addr    = ADDR_WIDTH'(bitrev(32'(wcnt), ADDR_WIDTH));
        full_set   = 2'b00;
        err_set    = 1'b0;
        if (sig_vld_i) begin
            if (sig_start_i) begin
                if (wstate == W_FILL) begin
                    err_set = 1'b1;
                end
                if (wfull) begin
                    err_set    = 1'b1;
                    wstate_nxt = W_WAIT;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wcnt_nxt   = ADDR_WIDTH'(1);
                    wstate_nxt = W_FILL;
                end
            end else if (wstate == W_WAIT) begin
                err_set = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wcnt_nxt = wcnt + 1'b1;
                if (wcnt == LAST_ADDR) begin
                    full_set   = 2'b01 << wbank;
                    wbank_nxt  = ~wbank;
                    wstate_nxt = W_WAIT;
                end
            end
        end
    end

    always_comb begin
        rstate_nxt = rstate;
        rcnt_nxt   = rcnt;
        rbank_nxt  = rbank;
        case (rstate)
            R_IDLE: begin
                if (full[rbank]) begin
                    rstate_nxt = R_READ;
                    rcnt_nxt   = '0;
                end
            end
            R_READ: begin
                rcnt_nxt = rcnt + 1'b1;
                if (rcnt == LAST_ADDR) begin
                    rbank_nxt = ~rbank;
                    if (!full[~rbank]) begin
                        rstate_nxt = R_IDLE;
                    end
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate <= W_WAIT;
            wcnt   <= '0;
            wbank  <= 1'b0;
            rstate <= R_IDLE;
            rcnt   <= '0;
            rbank  <= 1'b0;
            full   <= 2'b00;
            err    <= 1'b0;
        end else begin
            wstate <= wstate_nxt;
            wcnt   <= wcnt_nxt;
            wbank  <= wbank_nxt;
            rstate <= rstate_nxt;
            rcnt   <= rcnt_nxt;
            rbank  <= rbank_nxt;
            full   <= (full & ~full_clr) | full_set;
            err    <= err | err_set;
        end
    end

    ram2p #(
        .DATA_WIDTH (SW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RAM_RD_LATENCY)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_en && (wbank == 1'b0)),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_en   (issue && (rbank == 1'b0)),
        .rd_addr (rcnt),
        .rd_dat  (rd_dat0)
    );

    ram2p #(
        .DATA_WIDTH (SW),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LATENCY (RAM_RD_LATENCY)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_en && (wbank == 1'b1)),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_en   (issue && (rbank == 1'b1)),
        .rd_addr (rcnt),
        .rd_dat  (rd_dat1)
    );

    assign dly_in = {issue, issue && (rcnt == '0), rbank};

    fft_delay #(
        .WIDTH (3),
        .DELAY (RAM_RD_LATENCY)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dly_in),
        .dout  (dly_out)
    );

    assign sig_vld_o   = dly_out[2];
    assign sig_start_o = dly_out[1];
    assign rd_sel      = dly_out[0];
    assign rd_sample   = rd_sel ? rd_dat1 : rd_dat0;
    assign sig_real_o  = sig_vld_o ? rd_sample[SW-1:DATA_WIDTH] : '0;
    assign sig_imag_o  = sig_vld_o ? rd_sample[DATA_WIDTH-1:0]  : '0;
    assign err_o       = err;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with 8-point frames: table of frame
// vectors plus hand-written back-to-back, restart, orphan and reset sequences.
module tb_fft_bitrev_reorder;

    localparam int DW  = 16;
    localparam int N   = 8;
    localparam int AW  = 3;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          vld_i = 1'b0;
    logic [DW-1:0] real_i = '0;
    logic [DW-1:0] imag_i = '0;
    logic          start_o, vld_o, err_o;
    logic [DW-1:0] real_o, imag_o;

    fft_bitrev_reorder #(
        .DATA_WIDTH     (DW),
        .STATE_N        (N),
        .ADDR_WIDTH     (AW),
        .RAM_RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_start_i (start_i),
        .sig_vld_i   (vld_i),
        .sig_real_i  (real_i),
        .sig_imag_i  (imag_i),
        .sig_start_o (start_o),
        .sig_vld_o   (vld_o),
        .sig_real_o  (real_o),
        .sig_imag_o  (imag_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][DW-1:0] in_re;
        logic [N-1:0][DW-1:0] in_im;
        logic [N-1:0][DW-1:0] ex_re;
        logic [N-1:0][DW-1:0] ex_im;
        logic                 gap;
    } vec_t;

    vec_t vecs [4];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last_accept = 0;

    logic [DW-1:0] q_re [$];
    logic [DW-1:0] q_im [$];
    logic          q_st [$];
    int            q_edge [$];

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (vld_o) begin
            q_re.push_back(real_o);
            q_im.push_back(imag_o);
            q_st.push_back(start_o);
            q_edge.push_back(edge_cnt);
        end
    end

    function automatic logic [N-1:0][DW-1:0] seq8(input int a0, input int a1, input int a2,
                                                  input int a3, input int a4, input int a5,
                                                  input int a6, input int a7);
        logic [N-1:0][DW-1:0] r;
        r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
        r[4] = DW'(a4); r[5] = DW'(a5); r[6] = DW'(a6); r[7] = DW'(a7);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_re.delete();
        q_im.delete();
        q_st.delete();
        q_edge.delete();
    endtask

    task automatic send_sample(input logic st, input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(negedge clk);
        start_i = st;
        vld_i   = 1'b1;
        real_i  = re;
        imag_i  = im;
        last_accept = edge_cnt + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            vld_i   = 1'b0;
            real_i  = '0;
            imag_i  = '0;
        end
    endtask

    task automatic send_vec(input int v, input logic gap);
        for (int k = 0; k < N; k++) begin
            send_sample(k == 0, vecs[v].in_re[k], vecs[v].in_im[k]);
            if (gap) idle(1);
        end
    endtask

    // Bounded wait for n output samples, then a quiet window to catch extras.
    task automatic wait_out(input int n, input string name);
        int t;
        t = 0;
        while (q_re.size() < n && t < 60) begin
            @(negedge clk);
            t++;
        end
        idle(12);
        chk($sformatf("%s out_count", name), q_re.size(), n);
    endtask

    task automatic check_frame(input int v, input int base, input string name);
        if (q_re.size() < base + N) begin
            chk($sformatf("%s frame_present", name), q_re.size(), base + N);
        end else begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s re[%0d]", name, i), q_re[base+i], vecs[v].ex_re[i]);
                chk($sformatf("%s im[%0d]", name, i), q_im[base+i], vecs[v].ex_im[i]);
                chk($sformatf("%s start[%0d]", name, i), q_st[base+i], (i == 0));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            vecs[0].in_re[k] = DW'(k);
            vecs[0].in_im[k] = '0;
            vecs[1].in_re[k] = DW'(10 + k);
            vecs[1].in_im[k] = DW'(100 + k);
            vecs[2].in_re[k] = DW'(7 - k);
            vecs[2].in_im[k] = DW'(16'h8000 + k);
        end
        vecs[0].ex_re = seq8(0, 4, 2, 6, 1, 5, 3, 7);
        vecs[0].ex_im = seq8(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0].gap   = 1'b0;
        vecs[1].ex_re = seq8(10, 14, 12, 16, 11, 15, 13, 17);
        vecs[1].ex_im = seq8(100, 104, 102, 106, 101, 105, 103, 107);
        vecs[1].gap   = 1'b0;
        vecs[2].ex_re = seq8(7, 3, 5, 1, 6, 2, 4, 0);
        vecs[2].ex_im = seq8(16'h8000, 16'h8004, 16'h8002, 16'h8006,
                             16'h8001, 16'h8005, 16'h8003, 16'h8007);
        vecs[2].gap   = 1'b0;
        vecs[3]       = vecs[0];
        vecs[3].gap   = 1'b1;

        // Reset state
        idle(2);
        chk("reset vld_o", vld_o, 0);
        chk("reset start_o", start_o, 0);
        chk("reset real_o", real_o, 0);
        chk("reset imag_o", imag_o, 0);
        chk("reset err_o", err_o, 0);
        rst_n = 1'b1;
        idle(2);

        // Single frames from the table, contiguous and gapped
        for (int v = 0; v < 4; v++) begin
            clear_q();
            send_vec(v, vecs[v].gap);
            idle(1);
            wait_out(N, $sformatf("vec%0d", v));
            check_frame(v, 0, $sformatf("vec%0d", v));
            if (q_edge.size() > 0)
                chk($sformatf("vec%0d latency", v), q_edge[0] - last_accept, LAT + 1);
            chk($sformatf("vec%0d err_o", v), err_o, 0);
        end

        // Three back-to-back frames
        clear_q();
        send_vec(0, 1'b0);
        send_vec(1, 1'b0);
        send_vec(2, 1'b0);
        idle(1);
        wait_out(3 * N, "b2b");
        check_frame(0, 0, "b2b f0");
        check_frame(1, N, "b2b f1");
        check_frame(2, 2 * N, "b2b f2");
        if (q_edge.size() == 3 * N) begin
            for (int i = 1; i < 3 * N; i++)
                chk($sformatf("b2b contiguous[%0d]", i), q_edge[i] - q_edge[0], i);
        end
        chk("b2b err_o", err_o, 0);

        // Restart at input sample 5
        clear_q();
        for (int k = 0; k < 5; k++) send_sample(k == 0, DW'(50 + k), '0);
        send_vec(1, 1'b0);
        idle(1);
        wait_out(N, "restart");
        check_frame(1, 0, "restart");
        chk("restart err_o", err_o, 1);

        // Orphan samples after a fresh reset
        idle(1);
        rst_n = 1'b0;
        idle(1);
        chk("orphan pre err_o", err_o, 0);
        rst_n = 1'b1;
        clear_q();
        for (int k = 0; k < 3; k++) send_sample(1'b0, DW'(k + 1), '0);
        idle(1);
        wait_out(0, "orphan");
        chk("orphan err_o", err_o, 1);

        // Reset while a frame is being output
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        clear_q();
        send_vec(0, 1'b0);
        idle(1);
        begin
            int t;
            t = 0;
            while (q_re.size() < 3 && t < 30) begin
                @(negedge clk);
                t++;
            end
            chk("midrst output_started", q_re.size() >= 3, 1);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst vld_o", vld_o, 0);
        chk("midrst start_o", start_o, 0);
        chk("midrst real_o", real_o, 0);
        chk("midrst imag_o", imag_o, 0);
        chk("midrst err_o", err_o, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        clear_q();
        send_vec(2, 1'b0);
        idle(1);
        wait_out(N, "postrst");
        check_frame(2, 0, "postrst");
        if (q_edge.size() > 0)
            chk("postrst latency", q_edge[0] - last_accept, LAT + 1);
        chk("postrst err_o", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
